// File: rtl/ram_scan_reader.sv
// ram_scan_reader: scans the display RAM read port address by address with a programmable dwell,
// capturing each word into registered address/data outputs for the display path.
module ram_scan_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              wrap,
  output logic              busy
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int WW = $clog2(READ_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [WW-1:0]     wait_cnt_q;
  logic [TW-1:0]     tick_cnt_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              wrap_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      wait_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      // enable low wins over everything, including a pending step or timer expiry
      if (!enable) begin
        state_q    <= IDLE;
        wait_cnt_q <= '0;
        tick_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= ISSUE;
          ISSUE: begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
          end
          WAIT: begin
            if (wait_cnt_q == WW'(READ_LAT - 1)) begin
              out_data_q  <= rd_data;
              out_addr_q  <= cur_addr_q;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
              tick_cnt_q  <= '0;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (step || tick_cnt_q == TW'(TICK_DIV - 1)) begin
              cur_addr_q <= cur_addr_q + 1'b1;
              wrap_q     <= &cur_addr_q;
              state_q    <= ISSUE;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign rd_en     = (state_q == ISSUE);
  assign rd_addr   = cur_addr_q;
  assign busy      = (state_q != IDLE);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_ram_scan_reader.sv
// tb_ram_scan_reader: directed bench with a 1-cycle-latency RAM preloaded mem[a]=a[3:0]^4'hA.
module tb_ram_scan_reader;
  logic       clk = 1'b0;
  logic       reset, enable, step;
  logic       rd_en, out_valid, wrap, busy;
  logic [4:0] rd_addr, out_addr;
  logic [3:0] rd_data, out_data;
  logic [3:0] mem [32];
  int errors = 0;
  int checks = 0;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .READ_LAT(1), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid),
    .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  initial for (int a = 0; a < 32; a++) mem[a] = 4'(a) ^ 4'hA;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_out_addr"}, 32'(out_addr), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_wrap"}, 32'(wrap), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_issue_addr(input logic [4:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en && rd_addr == a) && n < 400);
    check("reach_issue", 32'(rd_en && rd_addr == a), 1);
  endtask

  task automatic wait_valid_addr(input logic [4:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_addr == a) && n < 400);
    check("reach_valid", 32'(out_valid && out_addr == a), 1);
  endtask

  task automatic count_to_issue(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_en && n < 20);
  endtask

  initial begin
    int n, nvalid, bad, wraps, bad_wrap;
    logic [4:0] exp_a;
    reset = 1'b0; enable = 1'b0; step = 1'b0;
    #1 check_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1; enable = 1'b1;
    // test 1: first issue, capture and 6-cycle period
    @(negedge clk);
    check("t1_rd_en_c1", 32'(rd_en), 1);
    check("t1_rd_addr_c1", 32'(rd_addr), 0);
    check("t1_busy_c1", 32'(busy), 1);
    @(negedge clk);
    check("t1_rd_en_c2", 32'(rd_en), 0);
    @(negedge clk);
    check("t1_valid_c3", 32'(out_valid), 1);
    check("t1_out_addr_c3", 32'(out_addr), 0);
    check("t1_out_data_c3", 32'(out_data), 32'hA);
    repeat (3) @(negedge clk);
    check("t1_rd_en_c6", 32'(rd_en), 0);
    @(negedge clk);
    check("t1_rd_en_c7", 32'(rd_en), 1);
    check("t1_rd_addr_c7", 32'(rd_addr), 1);
    // test 2: full sweep 1..31 then 0, one wrap aligned with address 0 issue
    exp_a = 5'd1; nvalid = 0; bad = 0; wraps = 0; bad_wrap = 0;
    for (int c = 0; c < 250 && nvalid < 32; c++) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        if (!(rd_en && rd_addr == 5'd0)) bad_wrap++;
      end
      if (out_valid) begin
        if (out_addr != exp_a) bad++;
        if (out_data != (exp_a[3:0] ^ 4'hA)) bad++;
        if (exp_a == 5'd31) check("t2_data31", 32'(out_data), 32'h5);
        exp_a++;
        nvalid++;
      end
    end
    check("t2_nvalid", 32'(nvalid), 32);
    check("t2_seq_bad", 32'(bad), 0);
    check("t2_wraps", 32'(wraps), 1);
    check("t2_wrap_align", 32'(bad_wrap), 0);
    // test 3: step during WAIT ignored, step in 2nd HOLD cycle shortens dwell
    wait_issue_addr(5'd2);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    count_to_issue(n);
    check("t3_wait_step_period", 32'(2 + n), 6);
    check("t3_addr3", 32'(rd_addr), 3);
    repeat (3) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("t3_hold_step_rd_en", 32'(rd_en), 1);
    check("t3_hold_step_addr", 32'(rd_addr), 4);
    // test 4: drop enable in HOLD at 9, re-enable re-reads 9
    wait_valid_addr(5'd9);
    enable = 1'b0;
    @(negedge clk);
    check("t4_busy", 32'(busy), 0);
    check("t4_out_addr", 32'(out_addr), 9);
    check("t4_rd_en", 32'(rd_en), 0);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("t4_reissue_en", 32'(rd_en), 1);
    check("t4_reissue_addr", 32'(rd_addr), 9);
    repeat (2) @(negedge clk);
    check("t4_valid", 32'(out_valid), 1);
    check("t4_valid_addr", 32'(out_addr), 9);
    check("t4_valid_data", 32'(out_data), 32'h3);
    count_to_issue(n);
    check("t4_next_addr", 32'(rd_addr), 10);
    // test 6: drop enable in WAIT abandons capture
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t6_no_valid", 32'(out_valid), 0);
    check("t6_data_kept", 32'(out_data), 32'h3);
    check("t6_addr_kept", 32'(out_addr), 9);
    check("t6_busy", 32'(busy), 0);
    enable = 1'b1;
    // test 5: async reset mid-WAIT at 17
    wait_issue_addr(5'd17);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_zero("t5_async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_restart_en", 32'(rd_en), 1);
    check("t5_restart_addr", 32'(rd_addr), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
